// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch refill
// path and the data load/store path, with a per-access watchdog.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output logic              fetch_stall
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {OWN_INST, OWN_DATA} owner_e;

  localparam int WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e              state_q, state_d;
  owner_e              lastGnt_q, lastGnt_d;
  owner_e              owner_q, owner_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                memReq_q, memReq_d;
  logic                memWe_q, memWe_d;
  logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
  logic [DATA_W-1:0]   memWdata_q, memWdata_d;
  logic                iDone_q, iDone_d;
  logic                dDone_q, dDone_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   iRdata_q, iRdata_d;
  logic [DATA_W-1:0]   dRdata_q, dRdata_d;

  logic anyReq;
  logic grantData;
  logic timeoutHit;

  // Data wins only when alone or when fetch had the previous grant.
  assign anyReq     = i_req | d_req;
  assign grantData  = d_req & (~i_req | (lastGnt_q == OWN_INST));
  assign timeoutHit = (TIMEOUT != 0) && (wdog_q == WDOG_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lastGnt_q  <= OWN_DATA;
      owner_q    <= OWN_INST;
      wdog_q     <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      iDone_q    <= 1'b0;
      dDone_q    <= 1'b0;
      err_q      <= 1'b0;
      iRdata_q   <= '0;
      dRdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      lastGnt_q  <= lastGnt_d;
      owner_q    <= owner_d;
      wdog_q     <= wdog_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      iDone_q    <= iDone_d;
      dDone_q    <= dDone_d;
      err_q      <= err_d;
      iRdata_q   <= iRdata_d;
      dRdata_q   <= dRdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyReq) state_d = BUSY;
      BUSY:    if (mem_ack || timeoutHit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lastGnt_d  = lastGnt_q;
    owner_d    = owner_q;
    wdog_d     = wdog_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    iDone_d    = 1'b0;
    dDone_d    = 1'b0;
    err_d      = 1'b0;
    iRdata_d   = iRdata_q;
    dRdata_d   = dRdata_q;

    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (anyReq) begin
          memReq_d = 1'b1;
          if (grantData) begin
            owner_d    = OWN_DATA;
            lastGnt_d  = OWN_DATA;
            memWe_d    = d_we;
            memAddr_d  = d_addr;
            memWdata_d = d_wdata;
          end else begin
            owner_d    = OWN_INST;
            lastGnt_d  = OWN_INST;
            memWe_d    = 1'b0;
            memAddr_d  = i_addr;
            memWdata_d = '0;
          end
        end
      end

      BUSY: begin
        if (mem_ack) begin
          memReq_d = 1'b0;
          if (owner_q == OWN_INST) begin
            iDone_d  = 1'b1;
            iRdata_d = mem_rdata;
          end else begin
            dDone_d = 1'b1;
            // A store leaves the last load result visible.
            if (!memWe_q) dRdata_d = mem_rdata;
          end
        end else if (timeoutHit) begin
          memReq_d = 1'b0;
          err_d    = 1'b1;
          if (owner_q == OWN_INST) begin
            iDone_d  = 1'b1;
            iRdata_d = '0;
          end else begin
            dDone_d  = 1'b1;
            dRdata_d = '0;
          end
        end else if (TIMEOUT != 0) begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      RESP: begin
        wdog_d = '0;
      end

      default: begin
        wdog_d = '0;
      end
    endcase
  end

  assign mem_req     = memReq_q;
  assign mem_we      = memWe_q;
  assign mem_addr    = memAddr_q;
  assign mem_wdata   = memWdata_q;
  assign i_done      = iDone_q;
  assign d_done      = dDone_q;
  assign err         = err_q;
  assign i_rdata     = iRdata_q;
  assign d_rdata     = dRdata_q;
  assign fetch_stall = i_req & ~iDone_q;

endmodule
